// File: rtl/aes_mixcolumns_wddl_seq.sv
// Column-serial dual-rail (WDDL) AES MixColumns / InvMixColumns engine.
// One 32-bit column per evaluate phase; every datapath node returns to 0/0 between evaluations.
module aes_mixcolumns_wddl_seq #(
    parameter int NCOL   = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  inv,
    input  logic [32*NCOL-1:0]    sa_sr_p,
    input  logic [32*NCOL-1:0]    sa_sr_n,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*NCOL-1:0]    sa_mc_p,
    output logic [32*NCOL-1:0]    sa_mc_n,
    output logic                  dr_err
);

    localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [7:0] POLY = 8'h1b;

    typedef enum logic [1:0] {IDLE, PRECH, EVAL, DONE} state_t;

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] n;
    } dr8_t;

    // WDDL XOR: each rail is a positive (monotone) function, so 0/0 inputs give 0/0 out.
    function automatic dr8_t dr_xor(input dr8_t a, input dr8_t b);
        dr8_t r;
        r.p = (a.p & b.n) | (a.n & b.p);
        r.n = (a.p & b.p) | (a.n & b.n);
        return r;
    endfunction

    // xtime without any constant rail: the shifted-in zero is folded away, bit 0 is a[7].
    function automatic dr8_t dr_xtime(input dr8_t a);
        dr8_t r;
        r.p = {a.p[6:0], a.p[7]};
        r.n = {a.n[6:0], a.n[7]};
        for (int k = 1; k < 8; k++) begin
            if (POLY[k]) begin
                r.p[k] = (a.p[k-1] & a.n[7]) | (a.n[k-1] & a.p[7]);
                r.n[k] = (a.p[k-1] & a.p[7]) | (a.n[k-1] & a.n[7]);
            end
        end
        return r;
    endfunction

    state_t         state;
    logic [CW-1:0]  col;
    logic           mode;
    logic [31:0]    op_p;
    logic [31:0]    op_n;
    logic [31:0]    buf_p [NCOL];
    logic [31:0]    buf_n [NCOL];
    logic [31:0]    mc_p  [NCOL];
    logic [31:0]    mc_n  [NCOL];
    logic [31:0]    res_p;
    logic [31:0]    res_n;

    dr8_t a_b     [4];
    dr8_t x2      [4];
    dr8_t fwd     [4];
    dr8_t inv_res [4];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    genvar gi;
    generate
        for (gi = 0; gi < NCOL; gi++) begin : g_pack
            assign sa_mc_p[32*gi +: 32] = mc_p[gi];
            assign sa_mc_n[32*gi +: 32] = mc_n[gi];
        end

        for (gi = 0; gi < 4; gi++) begin : g_fwd
            localparam int I1 = (gi + 1) % 4;
            localparam int I2 = (gi + 2) % 4;
            localparam int I3 = (gi + 3) % 4;
            assign a_b[gi] = {op_p[31-8*gi -: 8], op_n[31-8*gi -: 8]};
            assign x2[gi]  = dr_xtime(a_b[gi]);
            assign fwd[gi] = dr_xor(dr_xor(x2[gi], dr_xor(x2[I1], a_b[I1])),
                                    dr_xor(a_b[I2], a_b[I3]));
        end

        if (INV_EN) begin : g_inv
            dr8_t x4 [4];
            dr8_t x8 [4];
            dr8_t m9 [4];
            dr8_t mb [4];
            dr8_t md [4];
            dr8_t me [4];
            for (gi = 0; gi < 4; gi++) begin : g_byte
                localparam int I1 = (gi + 1) % 4;
                localparam int I2 = (gi + 2) % 4;
                localparam int I3 = (gi + 3) % 4;
                assign x4[gi] = dr_xtime(x2[gi]);
                assign x8[gi] = dr_xtime(x4[gi]);
                assign m9[gi] = dr_xor(x8[gi], a_b[gi]);
                assign mb[gi] = dr_xor(m9[gi], x2[gi]);
                assign md[gi] = dr_xor(m9[gi], x4[gi]);
                assign me[gi] = dr_xor(dr_xor(x8[gi], x4[gi]), x2[gi]);
                assign inv_res[gi] = dr_xor(dr_xor(me[gi], mb[I1]),
                                            dr_xor(md[I2], m9[I3]));
            end
        end else begin : g_noinv
            for (gi = 0; gi < 4; gi++) begin : g_byte
                assign inv_res[gi] = fwd[gi];
            end
        end

        // Mode is a static control for the whole state, so a per-rail select keeps 0/0 at 0/0.
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign res_p[31-8*gi -: 8] = mode ? inv_res[gi].p : fwd[gi].p;
            assign res_n[31-8*gi -: 8] = mode ? inv_res[gi].n : fwd[gi].n;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            col    <= '0;
            mode   <= 1'b0;
            op_p   <= '0;
            op_n   <= '0;
            dr_err <= 1'b0;
            for (int c = 0; c < NCOL; c++) begin
                buf_p[c] <= '0;
                buf_n[c] <= '0;
                mc_p[c]  <= '0;
                mc_n[c]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int c = 0; c < NCOL; c++) begin
                            buf_p[c] <= sa_sr_p[32*c +: 32];
                            buf_n[c] <= sa_sr_n[32*c +: 32];
                            mc_p[c]  <= '0;
                            mc_n[c]  <= '0;
                        end
                        mode <= INV_EN ? inv : 1'b0;
                        col  <= '0;
                        if (|(~(sa_sr_p ^ sa_sr_n)))
                            dr_err <= 1'b1;
                        state <= PRECH;
                    end
                end
                PRECH: begin
                    op_p  <= buf_p[col];
                    op_n  <= buf_n[col];
                    state <= EVAL;
                end
                EVAL: begin
                    mc_p[col] <= res_p;
                    mc_n[col] <= res_n;
                    op_p      <= '0;
                    op_n      <= '0;
                    if (col == CW'(NCOL - 1)) begin
                        state <= DONE;
                    end else begin
                        col   <= col + 1'b1;
                        state <= PRECH;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mixcolumns_wddl_seq.sv
// Bench for aes_mixcolumns_wddl_seq: fixed vectors, random states against a GF(2^8) model,
// precharge, backpressure, dual-rail fault and mid-operation reset sequences.
module tb_aes_mixcolumns_wddl_seq;

    localparam int NCOL = 4;
    localparam int W    = 32 * NCOL;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         inv = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] sa_sr_p = '0;
    logic [W-1:0] sa_sr_n = '1;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sa_mc_p;
    logic [W-1:0] sa_mc_n;
    logic         dr_err;

    int tests = 0;
    int fails = 0;

    aes_mixcolumns_wddl_seq #(.NCOL(NCOL), .INV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
        .sa_sr_p(sa_sr_p), .sa_sr_n(sa_sr_n), .out_valid(out_valid), .out_ready(out_ready),
        .sa_mc_p(sa_mc_p), .sa_mc_n(sa_mc_n), .dr_err(dr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--)
            if (prod[i]) prod ^= 15'(9'h11b) << (i - 8);
        return prod[7:0];
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic iv);
        logic [7:0]  coef [4];
        logic [7:0]  a [4];
        logic [7:0]  acc;
        logic [31:0] r;
        if (iv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int j = 0; j < 4; j++) a[j] = c[31-8*j -: 8];
        r = '0;
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j - i + 4) % 4], a[j]);
            r[31-8*i -: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] mix_state(input logic [W-1:0] s, input logic iv);
        logic [W-1:0] r;
        for (int c = 0; c < NCOL; c++) r[32*c +: 32] = mix_col(s[32*c +: 32], iv);
        return r;
    endfunction

    // Runs one state from an IDLE negedge through the output handshake; hold = DONE cycles with out_ready low.
    task automatic do_op(input logic iv, input logic [W-1:0] p, input logic [W-1:0] n,
                         input logic exp_err, input int hold,
                         output logic [W-1:0] rp, output logic [W-1:0] rn);
        int k;
        check1("in_ready_before_accept", in_ready, 1'b1);
        inv = iv; sa_sr_p = p; sa_sr_n = n; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        inv = ~iv;
        check1("dr_err_after_accept", dr_err, exp_err);
        k = 0;
        while (!out_valid && k < 4*NCOL + 4) begin
            if (k % 2 == 0) begin
                check("operand_precharge", W'({dut.op_p, dut.op_n}), '0);
                for (int c = k/2; c < NCOL; c++)
                    check("unwritten_column", W'({sa_mc_p[32*c +: 32], sa_mc_n[32*c +: 32]}), '0);
            end else begin
                check("operand_eval", W'({dut.op_p, dut.op_n}),
                      W'({p[32*(k/2) +: 32], n[32*(k/2) +: 32]}));
            end
            @(posedge clk); @(negedge clk);
            k++;
        end
        check("latency", W'(k), W'(2*NCOL));
        check1("out_valid_done", out_valid, 1'b1);
        check1("in_ready_done", in_ready, 1'b0);
        check("operand_done", W'({dut.op_p, dut.op_n}), '0);
        rp = sa_mc_p;
        rn = sa_mc_n;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; sa_sr_p = ~p; sa_sr_n = ~p;
            @(posedge clk); @(negedge clk);
            check1("hold_out_valid", out_valid, 1'b1);
            check1("hold_in_ready", in_ready, 1'b0);
            check("hold_mc_p", sa_mc_p, rp);
            check("hold_mc_n", sa_mc_n, rn);
        end
        in_valid = 1'b0;
        if (hold > 0) check1("hold_dr_err", dr_err, exp_err);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check1("out_valid_after_take", out_valid, 1'b0);
        check1("in_ready_after_take", in_ready, 1'b1);
    endtask

    typedef struct {
        logic         iv;
        logic [W-1:0] p;
        logic [W-1:0] e;
    } vec_t;

    vec_t         tab [4];
    logic [W-1:0] rp, rn, p, n, exp_v;
    logic         iv;

    initial begin
        tab[0] = '{1'b0, 128'hc6c6c6c6_01010101_f20a225c_db135345,
                         128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc};
        tab[1] = '{1'b1, 128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc,
                         128'hc6c6c6c6_01010101_f20a225c_db135345};
        tab[2] = '{1'b0, '0, '0};
        tab[3] = '{1'b1, '1, '1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("reset_in_ready", in_ready, 1'b1);
        check1("reset_out_valid", out_valid, 1'b0);
        check("reset_mc", W'({sa_mc_p, sa_mc_n}), '0);
        check1("reset_dr_err", dr_err, 1'b0);
        check("reset_operand", W'({dut.op_p, dut.op_n}), '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            do_op(tab[i].iv, tab[i].p, ~tab[i].p, 1'b0, 0, rp, rn);
            check("vector_p", rp, tab[i].e);
            check("vector_n", rn, ~tab[i].e);
        end

        // Backpressure with a faulty in_valid held during DONE.
        p = {$urandom, $urandom, $urandom, $urandom};
        do_op(1'b0, p, ~p, 1'b0, 5, rp, rn);
        check("backpressure_p", rp, mix_state(p, 1'b0));
        check("backpressure_n", rn, ~mix_state(p, 1'b0));

        for (int i = 0; i < 20; i++) begin
            p  = {$urandom, $urandom, $urandom, $urandom};
            iv = 1'($urandom_range(0, 1));
            do_op(iv, p, ~p, 1'b0, (i % 5 == 0) ? 2 : 0, rp, rn);
            exp_v = mix_state(p, iv);
            check("random_p", rp, exp_v);
            check("random_n", rn, ~exp_v);
        end

        // Bit 0 carries p = n = 1.
        p = {$urandom, $urandom, $urandom, $urandom};
        p[0] = 1'b1;
        n = ~p;
        n[0] = 1'b1;
        do_op(1'b0, p, n, 1'b1, 0, rp, rn);
        p = {$urandom, $urandom, $urandom, $urandom};
        do_op(1'b1, p, ~p, 1'b1, 0, rp, rn);
        check("clean_after_fault_p", rp, mix_state(p, 1'b1));
        check1("dr_err_sticky", dr_err, 1'b1);

        // Reset during the evaluate phase of column 2.
        p = {$urandom, $urandom, $urandom, $urandom};
        inv = 1'b0; sa_sr_p = p; sa_sr_n = ~p; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("partial_cols_p", W'(sa_mc_p[63:0]), W'(mix_state(p, 1'b0)[63:0]));
        rst = 1'b1;
        #1;
        check1("midrst_in_ready", in_ready, 1'b1);
        check1("midrst_out_valid", out_valid, 1'b0);
        check("midrst_mc", W'({sa_mc_p, sa_mc_n}), '0);
        check1("midrst_dr_err", dr_err, 1'b0);
        check("midrst_operand", W'({dut.op_p, dut.op_n}), '0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2*NCOL + 2; i++) begin
            @(posedge clk); @(negedge clk);
            check1("midrst_no_out_valid", out_valid, 1'b0);
        end
        p = {$urandom, $urandom, $urandom, $urandom};
        do_op(1'b0, p, ~p, 1'b0, 0, rp, rn);
        check("after_reset_p", rp, mix_state(p, 1'b0));
        check("after_reset_n", rn, ~mix_state(p, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_mixcolumns_wddl_seq.md
# aes_mixcolumns_wddl_seq

Column-serial, dual-rail (WDDL) AES MixColumns / InvMixColumns engine with an explicit precharge/evaluate sequence and valid/ready handshakes. It accepts a full dual-rail state of NCOL columns, processes one 32-bit column per evaluate phase through a shared WDDL datapath, and returns the dual-rail result. It sits between ShiftRows and AddRoundKey in the dual-rail round datapath and replaces the fully parallel combinational MixColumns where area matters.

## Interface
- NCOL, 4: columns per state, 1..4; state width W = 32*NCOL.
- INV_EN, 1: 1 = InvMixColumns supported; 0 = `inv` ignored, forward only.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  input state present.
- in_ready  out  1  engine can accept (IDLE only).
- inv  in  1  mode, sampled on accept: 0 MixColumns, 1 InvMixColumns.
- sa_sr_p  in  W  true rail of input state.
- sa_sr_n  in  W  false rail of input state.
- out_valid  out  1  result present, held until taken.
- out_ready  in  1  consumer accepts result.
- sa_mc_p  out  W  true rail of result.
- sa_mc_n  out  W  false rail of result.
- dr_err  out  1  sticky dual-rail violation flag.

## Operation
- Layout: column c = bits [32c+31:32c]; byte 0 (sa0) = [32c+31:32c+24], byte 3 (sa3) = [32c+7:32c]. The same layout applies on both rails.
- GF(2^8) arithmetic uses reduction polynomial 0x11b. xtime(a) = {a[6:0],0} ^ (0x1b & {8{a[7]}}), built from WDDL gates so the true and false rails are computed separately.
- Forward output byte i = 2·a_i ^ 3·a_(i+1) ^ a_(i+2) ^ a_(i+3), with indices mod 4.
- Inverse output byte i = 0e·a_i ^ 0b·a_(i+1) ^ 0d·a_(i+2) ^ 09·a_(i+3).
- FSM states and transitions:
  - IDLE → PRECH on accept (in_valid & in_ready).
  - PRECH → EVAL.
  - EVAL → PRECH when col < NCOL-1, incrementing col.
  - EVAL → DONE when col = NCOL-1.
  - DONE → IDLE on out_valid & out_ready.
- On accept:
  - Latch sa_sr_p/n into the input buffer and latch the mode.
  - Clear sa_mc_p/n to all zero on both rails (precharge value).
  - Set col = 0.
- The operand register feeds the shared datapath:
  - It holds 0 on both rails in IDLE, PRECH and DONE.
  - On the PRECH→EVAL edge it loads column col from the buffer.
  - On the EVAL exit edge it returns to 0/0.
- At the end of EVAL, the datapath result (both rails) is written into sa_mc column col. Other columns keep their value.
- Consequence: every datapath node returns to 0/0 between two evaluations, and no column result is ever overwritten in place.
- dr_err: set on accept if any bit position has sa_sr_p == sa_sr_n. It stays set until rst. The state is still processed.
- With INV_EN=0 the inverse coefficients are not built and the mode is forced to 0.

## Timing
- Reset values: state IDLE, col 0, in_ready 1, out_valid 0, sa_mc_p/n all 0, operand 0/0, dr_err 0.
- in_ready = (state == IDLE). Combinational from state only; no dependence on in_valid.
- out_valid = (state == DONE). sa_mc_p/n are stable while out_valid is high.
- Latency: accept at edge 0 → out_valid high after edge 2·NCOL. NCOL=4 gives 8 cycles; NCOL=1 gives 2 cycles.
- Throughput:
  - Next accept is possible no earlier than the edge after the DONE→IDLE handshake, giving a minimum period of 2·NCOL+2 cycles.
  - There is no overlap between consecutive states.
- Backpressure: DONE is held indefinitely while out_ready=0. Outputs, operand (0/0) and dr_err are frozen.
- Inputs are ignored outside IDLE; in_valid may stay high.
- Asynchronous rst at any point (mid-EVAL included) forces all reset values immediately. A partially computed result is discarded and out_valid never rises for that state.

## Test plan
- Forward, NCOL=4, four columns db135345 / f20a225c / 01010101 / c6c6c6c6 with n-rail = ~p → out_valid after exactly 8 cycles. Result columns are 8e4da1bc / 9fdc589d / 01010101 / c6c6c6c6, sa_mc_n = ~sa_mc_p, dr_err 0.
- Inverse, inv=1, columns 8e4da1bc / 9fdc589d / 01010101 / c6c6c6c6 → columns db135345 / f20a225c / 01010101 / c6c6c6c6.
- Precharge check: during every PRECH cycle, operand p and n both read 0x00000000. Unwritten result columns read 0/0 until their EVAL completes.
- Backpressure: out_ready held 0 for 5 cycles in DONE → out_valid stays 1, outputs unchanged, in_ready 0. A second in_valid during this time is not accepted. The handshake then returns in_ready=1 on the next cycle.
- Dual-rail fault: input with bit 0 set p=n=1 → dr_err=1 from the cycle after accept. It stays 1 across the next clean state and clears only on rst.
- Reset mid-op: assert rst during the EVAL of column 2 → in_ready=1, out_valid=0 and sa_mc all zero immediately. A fresh state then completes normally in 8 cycles.
